// File: rtl/int_ctx_stack_pkg.sv
// rtl/int_ctx_stack_pkg.sv - shared flag indices, FSM states and entry layout for the context stack
package int_ctx_stack_pkg;

    // ALU flag bit positions inside the {Z,C,N,V} vector
    localparam int Z_FLAG = 3;
    localparam int C_FLAG = 2;
    localparam int N_FLAG = 1;
    localparam int V_FLAG = 0;

    typedef enum logic {
        CTX_IDLE    = 1'b0,
        CTX_RESTORE = 1'b1
    } ctx_state_e;

    // Entry layout, LSB first: flags, then IE, then PC
    localparam int FLAGS_LSB = 0;

    function automatic int ie_bit(input int flag_width);
        return flag_width;
    endfunction

    function automatic int pc_lsb(input int flag_width);
        return flag_width + 1;
    endfunction

    function automatic int entry_width(input int pc_width, input int flag_width);
        return pc_width + 1 + flag_width;
    endfunction

endpackage

// File: rtl/ctx_lifo_mem.sv
// rtl/ctx_lifo_mem.sv - register-array LIFO with occupancy count and full/empty guards
module ctx_lifo_mem #(
    parameter int DEPTH = 16,
    parameter int DW    = 13
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          push_i,
    input  logic          pop_i,
    input  logic [DW-1:0] wdata_i,
    output logic [DW-1:0] rdata_o,
    output logic          full_o,
    output logic          empty_o
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [DW-1:0] mem_q [DEPTH];
    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;
    logic          push_ok;
    logic          pop_ok;

    assign full_o  = (count_q == CW'(DEPTH));
    assign empty_o = (count_q == '0);

    // Simultaneous push and pop is illegal, so neither side moves
    assign push_ok = push_i && !pop_i && !full_o;
    assign pop_ok  = pop_i && !push_i && !empty_o;

    // Top entry; the low-bit index wraps harmlessly when empty and reads entry DEPTH-1 when full
    assign rdata_o = mem_q[count_q[AW-1:0] - AW'(1)];

    // Occupancy next-state: saturates by guard, never wraps
    always_comb begin
        count_d = count_q;
        if (push_ok) begin
            count_d = count_q + CW'(1);
        end else if (pop_ok) begin
            count_d = count_q - CW'(1);
        end
    end

    // Occupancy register
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    // Entry storage is intentionally not reset
    always_ff @(posedge clk_i) begin
        if (push_ok) begin
            mem_q[count_q[AW-1:0]] <= wdata_i;
        end
    end

endmodule

// File: rtl/int_ctx_stack.sv
// rtl/int_ctx_stack.sv - call/interrupt context stack restoring PC, ALU flags and IE
module int_ctx_stack
    import int_ctx_stack_pkg::*;
#(
    parameter int DEPTH      = 16,
    parameter int PC_WIDTH   = 8,
    parameter int FLAG_WIDTH = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  push,
    input  logic                  pop,
    input  logic                  rti,
    input  logic [PC_WIDTH-1:0]   pc_in,
    input  logic [FLAG_WIDTH-1:0] flags_in,
    input  logic                  ie_in,
    input  logic                  err_clr,
    output logic [PC_WIDTH-1:0]   pc_out,
    output logic                  pc_wr,
    output logic [FLAG_WIDTH-1:0] flag_dout,
    output logic                  flag_wr,
    output logic                  ie_dout,
    output logic                  ie_wr,
    output logic                  busy,
    output logic                  empty,
    output logic                  full,
    output logic                  stack_err
);
    localparam int EW  = entry_width(PC_WIDTH, FLAG_WIDTH);
    localparam int IEB = ie_bit(FLAG_WIDTH);
    localparam int PCL = pc_lsb(FLAG_WIDTH);

    ctx_state_e            state_q;
    ctx_state_e            state_d;
    logic [PC_WIDTH-1:0]   pc_q;
    logic [FLAG_WIDTH-1:0] flags_q;
    logic                  ie_q;
    logic                  rti_q;
    logic                  err_q;
    logic [EW-1:0]         rdata;
    logic                  mem_push;
    logic                  mem_pop;
    logic                  pop_go;
    logic                  err_set;

    // Pops are only offered to the LIFO while idle; a pop during restore must not move count
    assign mem_push = push && !pop;
    assign mem_pop  = pop && !push && (state_q == CTX_IDLE);
    assign pop_go   = mem_pop && !empty;

    assign err_set = (push && pop)
                   || (push && !pop && full)
                   || (pop && !push && (empty || (state_q == CTX_RESTORE)));

    ctx_lifo_mem #(
        .DEPTH (DEPTH),
        .DW    (EW)
    ) u_lifo (
        .clk_i   (clk),
        .rst_ni  (rst_n),
        .push_i  (mem_push),
        .pop_i   (mem_pop),
        .wdata_i ({pc_in, ie_in, flags_in}),
        .rdata_o (rdata),
        .full_o  (full),
        .empty_o (empty)
    );

    // Restore FSM: one RESTORE cycle per accepted pop, strobes decoded from state
    always_comb begin
        state_d = CTX_IDLE;
        pc_wr   = 1'b0;
        flag_wr = 1'b0;
        ie_wr   = 1'b0;
        busy    = 1'b0;
        case (state_q)
            CTX_IDLE: begin
                if (pop_go) begin
                    state_d = CTX_RESTORE;
                end
            end
            CTX_RESTORE: begin
                pc_wr   = 1'b1;
                busy    = 1'b1;
                flag_wr = rti_q;
                ie_wr   = rti_q;
            end
            default: state_d = CTX_IDLE;
        endcase
    end

    // FSM state register; async reset kills any in-flight restore
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= CTX_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Capture the popped entry; flags and IE only change on an RTI
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q    <= '0;
            flags_q <= '0;
            ie_q    <= 1'b0;
            rti_q   <= 1'b0;
        end else if (pop_go) begin
            pc_q  <= rdata[PCL +: PC_WIDTH];
            rti_q <= rti;
            if (rti) begin
                flags_q <= rdata[FLAGS_LSB +: FLAG_WIDTH];
                ie_q    <= rdata[IEB];
            end
        end
    end

    // Sticky error; a new error beats a simultaneous clear
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_q <= 1'b0;
        end else if (err_set) begin
            err_q <= 1'b1;
        end else if (err_clr) begin
            err_q <= 1'b0;
        end
    end

    assign pc_out    = pc_q;
    assign flag_dout = flags_q;
    assign ie_dout   = ie_q;
    assign stack_err = err_q;

endmodule

// File: tb/tb_int_ctx_stack.sv
// tb/tb_int_ctx_stack.sv - scoreboard bench for int_ctx_stack against a queue-based stack model
module tb_int_ctx_stack;
    localparam int DEPTH = 16;
    localparam int PW    = 8;
    localparam int FW    = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          push = 1'b0;
    logic          pop = 1'b0;
    logic          rti = 1'b0;
    logic [PW-1:0] pc_in = '0;
    logic [FW-1:0] flags_in = '0;
    logic          ie_in = 1'b0;
    logic          err_clr = 1'b0;
    logic [PW-1:0] pc_out;
    logic          pc_wr;
    logic [FW-1:0] flag_dout;
    logic          flag_wr;
    logic          ie_dout;
    logic          ie_wr;
    logic          busy;
    logic          empty;
    logic          full;
    logic          stack_err;

    int_ctx_stack #(.DEPTH(DEPTH), .PC_WIDTH(PW), .FLAG_WIDTH(FW)) dut (
        .clk(clk), .rst_n(rst_n), .push(push), .pop(pop), .rti(rti),
        .pc_in(pc_in), .flags_in(flags_in), .ie_in(ie_in), .err_clr(err_clr),
        .pc_out(pc_out), .pc_wr(pc_wr), .flag_dout(flag_dout), .flag_wr(flag_wr),
        .ie_dout(ie_dout), .ie_wr(ie_wr), .busy(busy), .empty(empty), .full(full),
        .stack_err(stack_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [PW-1:0] pc;
        logic          rti;
        logic [FW-1:0] fl;
        logic          ie;
    } exp_t;

    typedef struct {
        logic [PW-1:0] pc;
        logic [FW-1:0] fl;
        logic          ie;
    } ent_t;

    exp_t          expq[$];
    ent_t          mstack[$];
    bit            mbusy;
    bit            merr;
    logic [FW-1:0] mfl;
    logic          mie;
    logic [PW-1:0] last_pc;
    logic [FW-1:0] last_fl;
    logic          last_ie;
    int            checks = 0;
    int            errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        expq.delete();
        mstack.delete();
        mbusy = 0; merr = 0; mfl = '0; mie = 1'b0;
        last_pc = '0; last_fl = '0; last_ie = 1'b0;
        #1;
        chk("rst_pc_wr", pc_wr, 0);
        chk("rst_flag_wr", flag_wr, 0);
        chk("rst_ie_wr", ie_wr, 0);
        chk("rst_busy", busy, 0);
        chk("rst_err", stack_err, 0);
        chk("rst_empty", empty, 1);
        chk("rst_full", full, 0);
        chk("rst_outs", {pc_out, flag_dout, ie_dout}, 0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    // One clock of stimulus; the model predicts the effect of the coming edge
    task automatic cycle(input bit p, input bit q, input bit r, input logic [PW-1:0] pc,
                         input logic [FW-1:0] fl, input logic iev, input bit clr);
        bit   e;
        bit   nb;
        ent_t ent;
        exp_t x;
        push = p; pop = q; rti = r; pc_in = pc; flags_in = fl; ie_in = iev; err_clr = clr;
        e = 0; nb = 0;
        if (p && q) begin
            e = 1;
        end else if (p) begin
            if (mstack.size() == DEPTH) e = 1;
            else begin
                ent.pc = pc; ent.fl = fl; ent.ie = iev;
                mstack.push_back(ent);
            end
        end else if (q) begin
            if (mbusy || mstack.size() == 0) e = 1;
            else begin
                ent = mstack.pop_back();
                if (r) begin
                    mfl = ent.fl; mie = ent.ie;
                end
                x.pc = ent.pc; x.rti = r; x.fl = mfl; x.ie = mie;
                expq.push_back(x);
                nb = 1;
            end
        end
        merr  = e ? 1'b1 : (clr ? 1'b0 : merr);
        mbusy = nb;
        @(posedge clk);
        #1;
        push = 0; pop = 0; err_clr = 0;
        chk("stack_err", stack_err, merr);
        chk("empty", empty, mstack.size() == 0);
        chk("full", full, mstack.size() == DEPTH);
        chk("busy", busy, mbusy);
    endtask

    task automatic idle();
        cycle(0, 0, 0, '0, '0, 1'b0, 0);
    endtask

    // Monitor: consumes one expected restore per PC strobe, otherwise checks outputs hold
    initial begin
        exp_t x;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (pc_wr) begin
                    chk("strobe_expected", expq.size() != 0, 1);
                    if (expq.size() != 0) begin
                        x = expq.pop_front();
                        chk("pc_out", pc_out, x.pc);
                        chk("flag_wr", flag_wr, x.rti);
                        chk("ie_wr", ie_wr, x.rti);
                        chk("flag_dout", flag_dout, x.fl);
                        chk("ie_dout", ie_dout, x.ie);
                        last_pc = x.pc; last_fl = x.fl; last_ie = x.ie;
                    end
                end else begin
                    chk("idle_strobes", {flag_wr, ie_wr}, 0);
                    chk("hold_outs", {pc_out, flag_dout, ie_dout}, {last_pc, last_fl, last_ie});
                end
            end
        end
    end

    initial begin
        int r;
        do_reset();

        // Single push then RTI
        cycle(1, 0, 0, 8'h3A, 4'b1010, 1'b1, 0);
        cycle(0, 1, 1, '0, '0, 1'b0, 0);
        idle();

        // Nested calls, RTS then RTI
        cycle(1, 0, 0, 8'h10, 4'b0110, 1'b1, 0);
        cycle(1, 0, 0, 8'h20, 4'b1001, 1'b0, 0);
        cycle(0, 1, 0, '0, '0, 1'b0, 0);
        idle();
        cycle(0, 1, 1, '0, '0, 1'b0, 0);
        idle();

        // Overflow: 17 pushes, then drain 16
        for (int i = 0; i < 17; i++) cycle(1, 0, 0, PW'(8'h40 + i), FW'(i), i[0], 0);
        for (int i = 0; i < 16; i++) begin
            cycle(0, 1, i[1], '0, '0, 1'b0, 0);
            idle();
        end
        cycle(0, 0, 0, '0, '0, 1'b0, 1);

        // Underflow then clear
        cycle(0, 1, 1, '0, '0, 1'b0, 0);
        idle();
        cycle(0, 0, 0, '0, '0, 1'b0, 1);

        // Push+pop conflict at count 3, then pop during restore
        for (int i = 0; i < 3; i++) cycle(1, 0, 0, PW'(8'h70 + i), FW'(3 - i), 1'b1, 0);
        cycle(1, 1, 1, 8'hEE, 4'hF, 1'b0, 0);
        idle();
        cycle(0, 1, 1, '0, '0, 1'b0, 1);
        cycle(0, 1, 1, '0, '0, 1'b0, 0);
        idle();
        cycle(0, 0, 0, '0, '0, 1'b0, 1);
        for (int i = 0; i < 2; i++) begin
            cycle(0, 1, 0, '0, '0, 1'b0, 0);
            idle();
        end

        // Reset in the middle of a restore
        cycle(1, 0, 0, 8'h55, 4'b1111, 1'b1, 0);
        cycle(0, 1, 1, '0, '0, 1'b0, 0);
        chk("restore_pc_wr", pc_wr, 1);
        do_reset();

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            r = $urandom_range(0, 9);
            cycle(r < 4 || r == 7, (r >= 4 && r <= 7) || r == 9, 1'($urandom),
                  PW'($urandom), FW'($urandom), 1'($urandom), $urandom_range(0, 7) == 0);
        end
        idle();
        idle();
        chk("pending_restores", expq.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
